// File: rtl/msi_pkg.sv
// Shared definitions for the MSI multi-vector engine.
//
// Contents:
//   cfg_sel_e     - register select encodings used on cfg_sel
//   msi_state_e   - message FSM states
//   CTRL_* consts - bit positions inside the ctrl register
//   MME_W, VEC_W  - width of the MMC/MME fields and of a vector index
//   compose_data  - builds the message data word for a given vector
package msi_pkg;

    typedef enum logic [2:0] {
        SEL_CTRL    = 3'd0,
        SEL_ADDR_LO = 3'd1,
        SEL_ADDR_HI = 3'd2,
        SEL_DATA    = 3'd3,
        SEL_MASK    = 3'd4,
        SEL_PENDING = 3'd5
    } cfg_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } msi_state_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MMC_LSB    = 1;
    localparam int CTRL_MME_LSB    = 4;
    localparam int CTRL_ADDR64_BIT = 7;
    localparam int CTRL_PVM_BIT    = 8;

    localparam int MME_W = 3;
    localparam int VEC_W = 5;

    // The low k bits of the programmed data are replaced by the vector
    // number, so a multi-vector function gets one data value per vector.
    function automatic logic [15:0] compose_data(
        input logic [15:0]      base,
        input logic [VEC_W-1:0] vec,
        input logic [MME_W-1:0] k
    );
        logic [15:0] low_mask;
        low_mask = (16'd1 << k) - 16'd1;
        return (base & ~low_mask) | ({11'd0, vec} & low_mask);
    endfunction

endpackage

// File: rtl/msi_vector_arbiter.sv
// Lowest-index priority encoder over the eligible vectors.
//
// Ports:
//   eligible - one bit per vector, 1 when the vector may be sent
//   grant    - one-hot grant of the lowest eligible vector (0 if none)
//   index    - binary index of the granted vector (0 if none)
module msi_vector_arbiter
    import msi_pkg::*;
#(
    parameter int NUM_VECTORS = 32
) (
    input  logic [NUM_VECTORS-1:0] eligible,
    output logic [NUM_VECTORS-1:0] grant,
    output logic [VEC_W-1:0]       index
);

    // Scan from the top down so that the lowest set bit is the last writer.
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/msi_multi_vector_engine.sv
// MSI multi-vector message engine.
//
// Collects one-cycle interrupt request pulses into per-vector pending bits,
// arbitrates among unmasked pending vectors (lowest index first) and hands
// one MSI write at a time to the TLP transmitter with a valid/ready
// handshake. Configuration registers mirror the MSI capability structure.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   cfg_wr_en    - register write strobe
//   cfg_sel      - register select (ctrl, addr_lo, addr_hi, data, mask, pending)
//   cfg_wdata    - register write data
//   cfg_rdata    - combinational read of the selected register
//   vec_req      - per-vector request pulses
//   msg_valid    - message available to the transmitter
//   msg_ready    - transmitter accepts the message
//   msg_addr     - message address (upper half zero without ADDR64)
//   msg_data     - message data, upper 16 bits zero
//   msg_vector   - vector number carried by the message
module msi_multi_vector_engine
    import msi_pkg::*;
#(
    parameter int NUM_VECTORS = 32,
    parameter int ADDR64      = 1,
    parameter int PVM         = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_en,
    input  logic [2:0]             cfg_sel,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    input  logic [NUM_VECTORS-1:0] vec_req,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [63:0]            msg_addr,
    output logic [31:0]            msg_data,
    output logic [VEC_W-1:0]       msg_vector
);

    localparam logic [MME_W-1:0] MMC = MME_W'($clog2(NUM_VECTORS));

    cfg_sel_e sel;
    assign sel = cfg_sel_e'(cfg_sel);

    logic                   msi_enable;
    logic [MME_W-1:0]       mme;
    logic [31:2]            addr_lo;
    logic [31:0]            addr_hi;
    logic [15:0]            data;
    logic [NUM_VECTORS-1:0] mask;
    logic [NUM_VECTORS-1:0] pending;

    msi_state_e state;
    msi_state_e next_state;

    logic [NUM_VECTORS-1:0] below_alloc;
    logic [NUM_VECTORS-1:0] top_alloc;
    logic [NUM_VECTORS-1:0] set_vec;
    logic [NUM_VECTORS-1:0] clr_vec;
    logic [NUM_VECTORS-1:0] eligible;
    logic [NUM_VECTORS-1:0] grant;
    logic [NUM_VECTORS-1:0] sent_grant;
    logic [VEC_W-1:0]       grant_index;
    logic [5:0]             alloc_cnt;
    logic                   any_eligible;
    logic                   launch;
    logic                   handshake;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msi_enable <= 1'b0;
            mme        <= '0;
            addr_lo    <= '0;
            addr_hi    <= '0;
            data       <= '0;
            mask       <= '0;
        end else if (cfg_wr_en) begin
            case (sel)
                SEL_CTRL: begin
                    msi_enable <= cfg_wdata[CTRL_EN_BIT];
                    // Software may ask for more vectors than exist; clamp.
                    mme <= (cfg_wdata[CTRL_MME_LSB +: MME_W] > MMC) ?
                           MMC : cfg_wdata[CTRL_MME_LSB +: MME_W];
                end
                SEL_ADDR_LO: addr_lo <= cfg_wdata[31:2];
                SEL_ADDR_HI: if (ADDR64 != 0) addr_hi <= cfg_wdata;
                SEL_DATA:    data <= cfg_wdata[15:0];
                SEL_MASK:    if (PVM != 0) mask <= cfg_wdata[NUM_VECTORS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (sel)
            SEL_CTRL: begin
                cfg_rdata[CTRL_EN_BIT]              = msi_enable;
                cfg_rdata[CTRL_MMC_LSB +: MME_W]    = MMC;
                cfg_rdata[CTRL_MME_LSB +: MME_W]    = mme;
                cfg_rdata[CTRL_ADDR64_BIT]          = (ADDR64 != 0);
                cfg_rdata[CTRL_PVM_BIT]             = (PVM != 0);
            end
            SEL_ADDR_LO: cfg_rdata = {addr_lo, 2'b00};
            SEL_ADDR_HI: cfg_rdata = addr_hi;
            SEL_DATA:    cfg_rdata = {16'd0, data};
            SEL_MASK:    cfg_rdata[NUM_VECTORS-1:0] = mask;
            // Without per-vector masking the pending bits still drive
            // arbitration but are hidden from software.
            SEL_PENDING: cfg_rdata[NUM_VECTORS-1:0] = (PVM != 0) ? pending : '0;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request folding and pending tracking
    // ------------------------------------------------------------------
    assign alloc_cnt = 6'd1 << mme;

    always_comb begin
        below_alloc = '0;
        top_alloc   = '0;
        for (int v = 0; v < NUM_VECTORS; v++) begin
            below_alloc[v] = (6'(v) < alloc_cnt);
            top_alloc[v]   = (6'(v) == (alloc_cnt - 6'd1));
        end
    end

    // Requests on unallocated vectors all land on the highest allocated one.
    assign set_vec = (vec_req & below_alloc) |
                     ((|(vec_req & ~below_alloc)) ? top_alloc : '0);

    assign handshake = msg_valid && msg_ready;
    assign clr_vec   = handshake ? sent_grant : '0;

    // Set wins over clear so a request arriving on the accept cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Vectors above the allocation keep their pending bit but never win.
    assign eligible     = pending & ~mask & below_alloc & {NUM_VECTORS{msi_enable}};
    assign any_eligible = |eligible;

    msi_vector_arbiter #(
        .NUM_VECTORS(NUM_VECTORS)
    ) u_arbiter (
        .eligible(eligible),
        .grant   (grant),
        .index   (grant_index)
    );

    // ------------------------------------------------------------------
    // Message FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (any_eligible) next_state = ST_SEND;
            ST_SEND: if (msg_ready)    next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        msg_valid = (state == ST_SEND);
    end

    assign launch = (state == ST_IDLE) && any_eligible;

    // Message fields are captured once at launch so later register writes,
    // masking or disabling cannot disturb a message already offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_addr   <= '0;
            msg_data   <= '0;
            msg_vector <= '0;
            sent_grant <= '0;
        end else if (launch) begin
            msg_addr   <= {((ADDR64 != 0) ? addr_hi : 32'd0), addr_lo, 2'b00};
            msg_data   <= {16'd0, compose_data(data, grant_index, mme)};
            msg_vector <= grant_index;
            sent_grant <= grant;
        end
    end

endmodule

// File: tb/tb_msi_multi_vector_engine.sv
`timescale 1ns/1ps
module tb_msi_multi_vector_engine;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr_en;
    logic [2:0]    cfg_sel;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic [N-1:0]  vec_req;
    logic          msg_valid;
    logic          msg_ready;
    logic [63:0]   msg_addr;
    logic [31:0]   msg_data;
    logic [4:0]    msg_vector;

    always #10 clk = ~clk;

    msi_multi_vector_engine #(
        .NUM_VECTORS(N),
        .ADDR64(1),
        .PVM(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr_en (cfg_wr_en),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .vec_req   (vec_req),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .msg_vector(msg_vector)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: register contents, a set of pending vectors and
    // at most one message in flight.
    bit          m_en;
    int          m_mme;
    logic [31:0] m_addr_lo, m_addr_hi, m_data, m_mask, m_pend;
    bit          m_busy;
    int          m_vec;
    logic [63:0] m_maddr;
    logic [31:0] m_mdata;

    task automatic model_reset();
        m_en = 0; m_mme = 0;
        m_addr_lo = 0; m_addr_hi = 0; m_data = 0; m_mask = 0; m_pend = 0;
        m_busy = 0; m_vec = 0; m_maddr = 0; m_mdata = 0;
    endtask

    function automatic logic [31:0] model_read(input int sel);
        case (sel)
            0: return 32'(int'(m_en) + 5 * 2 + m_mme * 16 + 128 + 256);
            1: return m_addr_lo;
            2: return m_addr_hi;
            3: return m_data;
            4: return m_mask;
            5: return m_pend;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int          a;
        int          win;
        bit          hs;
        logic [31:0] new_set;
        a       = 1 << m_mme;
        win     = -1;
        hs      = m_busy && msg_ready;
        new_set = 0;
        if (!m_busy && m_en) begin
            for (int v = 0; v < a; v++) begin
                if (m_pend[v] && !m_mask[v]) begin
                    win = v;
                    break;
                end
            end
        end
        for (int v = 0; v < N; v++)
            if (vec_req[v]) new_set[(v < a) ? v : a - 1] = 1'b1;
        if (hs) begin
            m_pend[m_vec] = 1'b0;
            m_busy = 0;
        end
        m_pend = m_pend | new_set;
        if (win >= 0) begin
            m_busy  = 1;
            m_vec   = win;
            m_maddr = {m_addr_hi, m_addr_lo};
            m_mdata = ((m_data >> m_mme) << m_mme) + 32'(win % a);
        end
        if (cfg_wr_en) begin
            case (int'(cfg_sel))
                0: begin
                    m_en  = cfg_wdata[0];
                    m_mme = int'(cfg_wdata[6:4]);
                    if (m_mme > 5) m_mme = 5;
                end
                1: m_addr_lo = cfg_wdata & 32'hFFFF_FFFC;
                2: m_addr_hi = cfg_wdata;
                3: m_data    = cfg_wdata & 32'h0000_FFFF;
                4: m_mask    = cfg_wdata;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        if (rst_n) begin
            check_val("msg_valid", 64'(msg_valid), 64'(m_busy));
            if (m_busy) begin
                check_val("msg_addr", msg_addr, m_maddr);
                check_val("msg_data", 64'(msg_data), 64'(m_mdata));
                check_val("msg_vector", 64'(msg_vector), 64'(m_vec));
            end
            check_val("cfg_rdata", 64'(cfg_rdata), 64'(model_read(int'(cfg_sel))));
        end
    endtask

    task automatic cfg_write(input int sel, input logic [31:0] wdata);
        cfg_wr_en = 1'b1;
        cfg_sel   = 3'(sel);
        cfg_wdata = wdata;
        tick();
        cfg_wr_en = 1'b0;
        cfg_sel   = 3'd5;
    endtask

    task automatic pulse(input logic [N-1:0] req);
        vec_req = req;
        tick();
        vec_req = '0;
    endtask

    task automatic check_reset_regs(input string tag);
        for (int s = 0; s < 6; s++) begin
            cfg_sel = 3'(s);
            #1;
            check_val($sformatf("%s_rd%0d", tag, s), 64'(cfg_rdata),
                      (s == 0) ? 64'h18A : 64'h0);
        end
        cfg_sel = 3'd5;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_sel   = 3'd5;
        cfg_wdata = '0;
        vec_req   = '0;
        msg_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        check_val("rst_valid", 64'(msg_valid), 64'd0);
        check_val("rst_addr", msg_addr, 64'd0);
        check_val("rst_data", 64'(msg_data), 64'd0);
        check_val("rst_vector", 64'(msg_vector), 64'd0);
        check_reset_regs("rst");
        rst_n = 1'b1;
        tick();

        // Basic send
        cfg_write(1, 32'hFEE0_0000);
        cfg_write(3, 32'h0000_1230);
        cfg_write(0, 32'h0000_0031);
        pulse(N'(1) << 5);
        check_val("basic_lat1", 64'(msg_valid), 64'd0);
        tick();
        check_val("basic_valid", 64'(msg_valid), 64'd1);
        check_val("basic_data", 64'(msg_data), 64'h1235);
        check_val("basic_addr", msg_addr, 64'hFEE0_0000);
        check_val("basic_vec", 64'(msg_vector), 64'd5);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        check_val("basic_pend_clr", 64'(cfg_rdata), 64'd0);
        check_val("basic_done", 64'(msg_valid), 64'd0);

        // Fold onto the top allocated vector
        cfg_write(0, 32'h0000_0011);
        pulse(N'(1) << 7);
        tick();
        check_val("fold_valid", 64'(msg_valid), 64'd1);
        check_val("fold_vec", 64'(msg_vector), 64'd1);
        check_val("fold_data", 64'(msg_data), 64'h1231);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;

        // Mask holds the vector pending without sending
        cfg_write(0, 32'h0000_0031);
        cfg_write(4, 32'h0000_0004);
        pulse(N'(1) << 2);
        repeat (3) tick();
        check_val("mask_pend", 64'(cfg_rdata), 64'h4);
        check_val("mask_novalid", 64'(msg_valid), 64'd0);
        cfg_write(4, 32'h0);
        tick();
        check_val("unmask_valid", 64'(msg_valid), 64'd1);
        check_val("unmask_vec", 64'(msg_vector), 64'd2);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        repeat (3) tick();
        check_val("unmask_once", 64'(msg_valid), 64'd0);

        // Priority and backpressure
        cfg_write(0, 32'h0000_0051);
        pulse((N'(1) << 9) | (N'(1) << 3));
        tick();
        check_val("prio_first", 64'(msg_vector), 64'd3);
        repeat (5) begin
            tick();
            check_val("bp_valid", 64'(msg_valid), 64'd1);
            check_val("bp_vec", 64'(msg_vector), 64'd3);
        end
        msg_ready = 1'b1;
        tick();
        check_val("prio_gap", 64'(msg_valid), 64'd0);
        tick();
        check_val("prio_second", 64'(msg_vector), 64'd9);
        check_val("prio_second_v", 64'(msg_valid), 64'd1);
        tick();
        msg_ready = 1'b0;
        check_val("prio_drained", 64'(cfg_rdata), 64'd0);

        // Set/clear collision then reset mid-send
        pulse(N'(1) << 4);
        tick();
        check_val("coll_vec", 64'(msg_vector), 64'd4);
        msg_ready = 1'b1;
        vec_req   = N'(1) << 4;
        tick();
        msg_ready = 1'b0;
        vec_req   = '0;
        check_val("coll_pend", 64'(cfg_rdata), 64'h10);
        tick();
        check_val("coll_again", 64'(msg_valid), 64'd1);
        check_val("coll_again_vec", 64'(msg_vector), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_valid", 64'(msg_valid), 64'd0);
        check_val("arst_addr", msg_addr, 64'd0);
        check_val("arst_data", 64'(msg_data), 64'd0);
        check_val("arst_vector", 64'(msg_vector), 64'd0);
        check_reset_regs("arst");
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cfg_wr_en = ($urandom_range(0, 7) == 0);
            cfg_sel   = 3'($urandom_range(0, 7));
            cfg_wdata = $urandom;
            if ($urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
            if ($urandom_range(0, 1) == 0) cfg_wdata[31:8] = '0;
            vec_req   = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom & $urandom) : '0;
            msg_ready = 1'($urandom_range(0, 1));
            tick();
        end
        cfg_wr_en = 1'b0;
        vec_req   = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msi_multi_vector_engine.md
MSI_MULTI_VECTOR_ENGINE -- requirements
Module: msi_multi_vector_engine

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 32, number of vector request inputs; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter ADDR64, default 1, enabling the 64-bit message address (upper address register present).
REQ-003 SHALL have parameter PVM, default 1, enabling per-vector mask and pending registers.
REQ-004 SHALL have a single clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_wr_en  in  1  config write strobe
- cfg_sel  in  3  register select: 0 ctrl, 1 addr_lo, 2 addr_hi, 3 data, 4 mask, 5 pending
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  combinational read of the register selected by cfg_sel
- vec_req  in  NUM_VECTORS  one-cycle interrupt request pulses
- msg_valid  out  1  message request to the TLP transmitter
- msg_ready  in  1  transmitter accept
- msg_addr  out  64  message address
- msg_data  out  32  message data, upper 16 bits zero
- msg_vector  out  5  vector being sent

Function
REQ-006 ctrl register SHALL be: bit0 msi_enable (RW); bits[3:1] MMC (RO, log2 NUM_VECTORS); bits[6:4] MME (RW); bit7 ADDR64 (RO); bit8 PVM (RO); all other bits read 0.
REQ-007 Writes to MME greater than MMC SHALL store MMC.
REQ-008 The allocated vector count SHALL be A = 2^MME; k = MME.
REQ-009 addr_lo bits[1:0] SHALL be hardwired 0. When ADDR64=0, addr_hi SHALL read 0, ignore writes, and drive msg_addr[63:32]=0.
REQ-010 The data register SHALL be fully writable in bits[15:0]; bits[31:16] SHALL read 0.
REQ-011 msg_data[15:0] SHALL equal {data[15:k], v[k-1:0]} for vector v; when k=0, msg_data[15:0] SHALL equal data.
REQ-012 A vec_req bit v with v >= A SHALL be folded onto vector A-1.
REQ-013 A request SHALL set pending[v] one cycle after the vec_req pulse, regardless of mask or msi_enable.
REQ-014 When PVM=0, the mask SHALL read 0 and ignore writes, and pending SHALL read 0, though it is still tracked internally. The pending register SHALL always be read-only.
REQ-015 A vector SHALL be eligible when pending, unmasked, below A, and msi_enable=1. The lowest eligible index SHALL win arbitration.
REQ-016 The FSM SHALL have states IDLE and SEND.
REQ-017 IDLE -> SEND SHALL occur when any vector is eligible; msg_addr, msg_data and msg_vector SHALL be latched on that transition.
REQ-018 In SEND, msg_valid SHALL be 1 and outputs SHALL hold stable until msg_ready=1. On handshake, pending[v] SHALL be cleared and the FSM SHALL return to IDLE.
REQ-019 Minimum latency SHALL be: vec_req at cycle N, msg_valid at cycle N+2. Messages SHALL be spaced at least 2 cycles apart.
REQ-020 A vec_req for the vector being handshaken in the same cycle SHALL leave pending set (set wins over clear).
REQ-021 Masking the vector, clearing msi_enable, or changing MME/address/data during SEND SHALL NOT abort the message; it SHALL complete with the latched values.
REQ-022 Lowering MME SHALL NOT clear pending bits at or above the new A; those vectors SHALL become ineligible only.
REQ-023 Multiple requests for an already-pending vector SHALL coalesce into one message.

Reset
REQ-024 On rst_n low, all registers SHALL clear to 0: msi_enable=0, MME=0, address=0, data=0, mask=0, pending=0. The FSM SHALL go to IDLE with msg_valid=0 and msg_addr/msg_data/msg_vector=0, asynchronously.
REQ-025 Reset asserted during SEND SHALL drop msg_valid immediately and discard the message.

Structure
REQ-026 Package msi_pkg SHALL hold the cfg_sel encodings (typedef enum), the ctrl bit positions, and the MME width constant.
REQ-027 Sub-module msi_vector_arbiter SHALL implement the lowest-index priority encoder over the eligible vector: NUM_VECTORS in, one-hot grant plus 5-bit index out.

Verification
REQ-028 Bench SHALL cover the following directed scenarios:
- Basic send: MME=3, data=0x1230, addr_lo=0xFEE00000, enable=1, pulse vec_req[5] -> msg_valid 2 cycles later, msg_data=0x1235, msg_addr=0xFEE00000; pending[5] clears after ready.
- Fold: MME=1, pulse vec_req[7] -> message with msg_vector=1, msg_data[0]=1.
- Mask: set mask[2], pulse vec_req[2] -> pending=0x4 and no msg_valid; unmask -> one message.
- Priority and backpressure: pulse vec_req[9] and vec_req[3] together, hold msg_ready=0 for 5 cycles -> vector 3 sent first with stable outputs, then vector 9.
- Set/clear collision and reset: re-pulse vec_req[4] on its handshake cycle -> a second message follows; assert rst_n low mid-SEND -> msg_valid=0 immediately and all registers read 0.
